mult_share_arb: RTL

Round-robin arbiter and sequencer that shares one pipelined W×W `multiplier` among N requesters. Each requester presents operands with a valid/ready handshake. The block issues at most one operation per cycle into the multiplier and tracks the requester ID of each in-flight operation through a tag pipeline matched to the multiplier latency. It returns each product with its requester ID and sits directly in front of the multiplier instance.

---
 rtl/mult_share_arb_if.sv | 31 +++
 rtl/mult_share_arb.sv | 109 ++++++++++
 2 files changed

// File: rtl/mult_share_arb_if.sv
// Bundle of request, multiplier-side and result signals for mult_share_arb.
// slave = arbiter side, master = requesters/multiplier/result consumer side.
interface mult_share_arb_if #(
  parameter int N = 4,
  parameter int W = 4
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic           mul_en;
  logic [2*W-1:0] mul_sum;
  logic           res_valid;
  logic [IDW-1:0] res_id;
  logic [2*W-1:0] res_data;
  logic           busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_sum,
    output req_ready, mul_a, mul_b, mul_en, res_valid, res_id, res_data, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_sum,
    input  req_ready, mul_a, mul_b, mul_en, res_valid, res_id, res_data, busy
  );
endinterface

// File: rtl/mult_share_arb.sv
// Shares one LAT-deep pipelined multiplier among N requesters, tagging each issue with its owner.
// Optional build macro MULT_SHARE_FIXED_PRIO_EN: fixed lowest-index priority instead of round-robin.
module mult_share_arb #(
  parameter int N   = 4,
  parameter int W   = 4,
  parameter int LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  mult_share_arb_if.slave    bus
);
  localparam int IDW = $clog2(N);

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tag_t;

  // Handshake: requester i holds req_valid[i]/operands stable until req_ready[i];
  // the transfer happens on the rising edge where both are 1. At most one grant per cycle.
  logic           any_valid;
  logic [IDW-1:0] gnt_id;
  logic [N-1:0]   ready_c;
  tag_t [LAT:0]   tag_q;
  logic           busy_c;

  assign any_valid = |bus.req_valid;

`ifdef MULT_SHARE_FIXED_PRIO_EN
  always_comb begin
    gnt_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) gnt_id = IDW'(i);
    end
  end
`else
  logic [IDW-1:0] ptr_q;
  logic           hi_found;
  logic [IDW-1:0] hi_id;
  logic [IDW-1:0] lo_id;

  // Lowest valid index at/above the pointer wins; otherwise wrap to the lowest valid index.
  always_comb begin
    hi_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        lo_id = IDW'(i);
        if (IDW'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_id    = IDW'(i);
        end
      end
    end
    gnt_id = hi_found ? hi_id : lo_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (any_valid) begin
      ptr_q <= (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
    end
  end
`endif

  always_comb begin
    ready_c = '0;
    if (any_valid) ready_c[gnt_id] = 1'b1;
  end

  assign bus.req_ready = ready_c;

  // The multiplier is never stalled; cycles without a grant enter as invalid tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mul_a  <= '0;
      bus.mul_b  <= '0;
      bus.mul_en <= 1'b0;
      tag_q      <= '0;
    end else begin
      bus.mul_en <= 1'b1;
      if (any_valid) begin
        bus.mul_a      <= bus.req_a[int'(gnt_id)*W +: W];
        bus.mul_b      <= bus.req_b[int'(gnt_id)*W +: W];
        tag_q[0].valid <= 1'b1;
        tag_q[0].id    <= gnt_id;
      end else begin
        tag_q[0] <= '0;
      end
      for (int s = 1; s <= LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  always_comb begin
    busy_c = 1'b0;
    for (int s = 0; s <= LAT; s++) begin
      busy_c = busy_c | tag_q[s].valid;
    end
  end

  assign bus.busy      = busy_c;
  assign bus.res_valid = tag_q[LAT].valid;
  assign bus.res_id    = tag_q[LAT].id;
  assign bus.res_data  = tag_q[LAT].valid ? bus.mul_sum : '0;
endmodule
